// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding logic.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;
  // Stage entries carry a fixed-width destination so the type is shared across REG_AW choices.
  localparam int HZ_DST_W = 16;

  typedef struct packed {
    logic                v;
    logic [HZ_DST_W-1:0] dst;
    logic                wr;
    logic                ld;
  } hz_entry_t;

  function automatic int sel_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_match.sv
// One source operand compared against every in-flight stage entry; the youngest writer wins.
module hz_match
  import pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  localparam int SEL_W     = sel_w(NUM_STAGES)
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_used,
  input  hz_entry_t         st [NUM_STAGES],
  output logic              hit,
  output logic [SEL_W-1:0]  idx,
  output logic              hazard
);

  // Scan oldest to youngest so the lowest matching stage index overwrites the result.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    hazard = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (src_used && (src_addr != '0) && st[i].v && st[i].wr &&
          (st[i].dst == HZ_DST_W'(src_addr))) begin
        hit    = 1'b1;
        idx    = SEL_W'(i);
        hazard = st[i].ld && (i < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: tracks in-flight destinations, stalls on load-use,
// selects forwarding sources, honours flush, and flags stalls that run too long.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int MAX_STALL  = 8,
  localparam int SEL_W     = sel_w(NUM_STAGES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic                      id_ready,
  output logic                      stall,
  output logic                      if_hold,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [7:0]                stall_cnt,
  output logic                      watchdog_err
);

  localparam logic [7:0] MAX_STALL_L = 8'(MAX_STALL);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  hz_entry_t          st [NUM_STAGES];
  logic [NUM_SRC-1:0] src_hit;
  logic [NUM_SRC-1:0] src_hz;
  logic [SEL_W-1:0]   src_idx [NUM_SRC];
  logic               hazard;
  logic               issue;
  logic [7:0]         stall_cnt_nxt;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hz_match #(
      .REG_AW    (REG_AW),
      .NUM_STAGES(NUM_STAGES),
      .LOAD_LAT  (LOAD_LAT)
    ) u_match (
      .src_addr(id_src_addr[k*REG_AW +: REG_AW]),
      .src_used(id_src_used[k]),
      .st      (st),
      .hit     (src_hit[k]),
      .idx     (src_idx[k]),
      .hazard  (src_hz[k])
    );
  end

  // ID decision: flush and reset both override any hazard.
  assign hazard   = |src_hz;
  assign issue    = id_valid & ~hazard & ~flush & ~reset;
  assign stall    = id_valid & hazard & ~flush & ~reset;
  assign id_ready = issue;
  assign if_hold  = stall;

  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!reset && src_hit[k] && !src_hz[k]) fwd_sel[k*SEL_W +: SEL_W] = src_idx[k] + SEL_W'(1);
    end
  end

  assign stall_cnt_nxt = stall ? sat_inc(stall_cnt) : 8'd0;

  // Stage shift: destination fields flow freely, only valid bits and counters see reset.
  always_ff @(posedge clk) begin
    st[0].dst <= HZ_DST_W'(id_dst_addr);
    st[0].wr  <= id_reg_write;
    st[0].ld  <= id_is_load;
    for (int i = 1; i < NUM_STAGES; i++) begin
      st[i].dst <= st[i-1].dst;
      st[i].wr  <= st[i-1].wr;
      st[i].ld  <= st[i-1].ld;
    end
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) st[i].v <= 1'b0;
      stall_cnt    <= 8'd0;
      watchdog_err <= 1'b0;
    end else begin
      st[0].v <= issue;
      for (int i = 1; i < NUM_STAGES; i++) st[i].v <= st[i-1].v;
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt >= MAX_STALL_L) watchdog_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_pipe_hazard_ctrl;

  localparam int A_NS  = 3;
  localparam int A_LL  = 1;
  localparam int A_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic       a_reset, a_valid, a_wr, a_ld, a_flush;
  logic [9:0] a_src;
  logic [1:0] a_used;
  logic [4:0] a_dst;
  logic       a_ready, a_stall, a_hold, a_wd;
  logic [3:0] a_fwd;
  logic [7:0] a_cnt;

  logic       b_reset, b_valid, b_wr, b_ld, b_flush;
  logic [9:0] b_src;
  logic [1:0] b_used;
  logic [4:0] b_dst;
  logic       b_ready, b_stall, b_hold, b_wd;
  logic [5:0] b_fwd;
  logic [7:0] b_cnt;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .reset(a_reset), .id_valid(a_valid), .id_src_addr(a_src), .id_src_used(a_used),
    .id_dst_addr(a_dst), .id_reg_write(a_wr), .id_is_load(a_ld), .flush(a_flush),
    .id_ready(a_ready), .stall(a_stall), .if_hold(a_hold), .fwd_sel(a_fwd),
    .stall_cnt(a_cnt), .watchdog_err(a_wd)
  );

  pipe_hazard_ctrl #(.NUM_STAGES(4), .LOAD_LAT(3), .MAX_STALL(2)) dut_b (
    .clk(clk), .reset(b_reset), .id_valid(b_valid), .id_src_addr(b_src), .id_src_used(b_used),
    .id_dst_addr(b_dst), .id_reg_write(b_wr), .id_is_load(b_ld), .flush(b_flush),
    .id_ready(b_ready), .stall(b_stall), .if_hold(b_hold), .fwd_sel(b_fwd),
    .stall_cnt(b_cnt), .watchdog_err(b_wd)
  );

  // Reference model: list of issued instructions with their age in cycles since issue.
  typedef struct {
    int age;
    int dst;
    bit wr;
    bit ld;
  } rec_t;

  rec_t mq[$];
  int   m_cnt;
  bit   m_wd;

  function automatic void model_eval(input logic [9:0] addr, input logic [1:0] used,
                                     output logic hz, output logic [3:0] sel);
    hz  = 1'b0;
    sel = '0;
    for (int k = 0; k < 2; k++) begin
      int a;
      int best;
      bit bld;
      a    = int'(addr[k*5 +: 5]);
      best = -1;
      bld  = 1'b0;
      if (used[k] && a != 0) begin
        foreach (mq[j]) begin
          if (mq[j].wr && mq[j].dst == a && (best < 0 || mq[j].age < best)) begin
            best = mq[j].age;
            bld  = mq[j].ld;
          end
        end
      end
      if (best >= 0) begin
        if (bld && best < A_LL) hz = 1'b1;
        else sel[k*2 +: 2] = 2'(best + 1);
      end
    end
  endfunction

  task automatic model_step(input bit rst, input bit iss, input logic [4:0] dst,
                            input bit wr, input bit ld, input bit stl);
    rec_t nq[$];
    if (rst) begin
      mq.delete();
      m_cnt = 0;
      m_wd  = 1'b0;
      return;
    end
    foreach (mq[j]) begin
      rec_t r;
      r = mq[j];
      r.age++;
      if (r.age < A_NS) nq.push_back(r);
    end
    mq = nq;
    if (iss) mq.push_back('{0, int'(dst), wr, ld});
    m_cnt = stl ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
    if (m_cnt >= A_MAX) m_wd = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst, input logic wr,
                         input logic ld, input logic fl);
    a_valid = v; a_src = {s1, s0}; a_used = used; a_dst = dst;
    a_wr = wr; a_ld = ld; a_flush = fl;
  endtask

  task automatic a_idle();
    a_drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (A_NS + 1) tick();
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    a_drive(1'b1, 5'd3, 5'd3, 2'b11, 5'd3, 1'b1, 1'b1, 1'b0);
    #1;
    n_run++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", a_ready); end
    n_run++; if (a_stall !== 1'b0 || a_hold !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b/%b want 0/0", a_stall, a_hold); end
    repeat (2) tick();
    n_run++; if (a_fwd !== 4'h0) begin n_fail++; $display("FAIL rst_fwd: got %h want 0", a_fwd); end
    n_run++; if (a_cnt !== 8'd0 || a_wd !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_wd: got %0d/%b want 0/0", a_cnt, a_wd); end
    n_run++; if (b_cnt !== 8'd0 || b_wd !== 1'b0) begin n_fail++; $display("FAIL rst_b_cnt_wd: got %0d/%b want 0/0", b_cnt, b_wd); end
    a_reset = 1'b0;
    #1;
    n_run++; if (a_fwd !== 4'h0 || a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release: got fwd %h ready %b want 0/1", a_fwd, a_ready); end
    a_idle();
  endtask

  task automatic test_forward();
    a_drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    n_run++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_issue: got %b want 1", a_ready); end
    tick();
    a_drive(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_run++; if (a_fwd[1:0] !== 2'd1 || a_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_ex: got sel %0d stall %b want 1/0", a_fwd[1:0], a_stall); end
    tick();
    #1;
    n_run++; if (a_fwd[1:0] !== 2'd2) begin n_fail++; $display("FAIL fwd_mem: got %0d want 2", a_fwd[1:0]); end
    a_idle();
  endtask

  task automatic test_load_use();
    a_drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    a_drive(1'b1, 5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_run++; if (a_stall !== 1'b1 || a_hold !== 1'b1 || a_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall: got stall %b hold %b ready %b want 1/1/0", a_stall, a_hold, a_ready); end
    n_run++; if (a_fwd[3:2] !== 2'd0) begin n_fail++; $display("FAIL lu_sel_zero: got %0d want 0", a_fwd[3:2]); end
    tick();
    n_run++; if (a_cnt !== 8'd1) begin n_fail++; $display("FAIL lu_cnt1: got %0d want 1", a_cnt); end
    #1;
    n_run++; if (a_fwd[3:2] !== 2'd2 || a_ready !== 1'b1 || a_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got sel %0d ready %b stall %b want 2/1/0", a_fwd[3:2], a_ready, a_stall); end
    tick();
    n_run++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL lu_cnt0: got %0d want 0", a_cnt); end
    a_idle();
  endtask

  task automatic test_youngest_r0();
    a_drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    a_drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    a_drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    a_drive(1'b1, 5'd7, 5'd0, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_run++; if (a_fwd !== 4'b0001) begin n_fail++; $display("FAIL youngest_r7: got %b want 0001", a_fwd); end
    tick();
    a_drive(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_run++; if (a_fwd !== 4'b0000 || a_stall !== 1'b0) begin n_fail++; $display("FAIL r0_read: got %b stall %b want 0000/0", a_fwd, a_stall); end
    a_idle();
  endtask

  task automatic test_flush();
    a_drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    a_drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    n_run++; if (a_ready !== 1'b0 || a_stall !== 1'b0 || a_hold !== 1'b0) begin n_fail++; $display("FAIL flush_ctrl: got ready %b stall %b hold %b want 0/0/0", a_ready, a_stall, a_hold); end
    tick();
    n_run++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", a_cnt); end
    a_drive(1'b1, 5'd5, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_run++; if (a_fwd !== 4'b0010 || a_ready !== 1'b1) begin n_fail++; $display("FAIL flush_bubble: got fwd %b ready %b want 0010/1", a_fwd, a_ready); end
    a_idle();
  endtask

  task automatic test_reset_mid_stall();
    a_drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    a_drive(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_run++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL rms_pre: got %b want 1", a_stall); end
    a_reset = 1'b1;
    #1;
    n_run++; if (a_stall !== 1'b0 || a_ready !== 1'b0 || a_hold !== 1'b0 || a_fwd !== 4'h0) begin n_fail++; $display("FAIL rms_during: got stall %b ready %b hold %b fwd %h want 0/0/0/0", a_stall, a_ready, a_hold, a_fwd); end
    tick();
    a_reset = 1'b0;
    #1;
    n_run++; if (a_stall !== 1'b0 || a_fwd !== 4'h0 || a_ready !== 1'b1) begin n_fail++; $display("FAIL rms_after: got stall %b fwd %h ready %b want 0/0/1", a_stall, a_fwd, a_ready); end
    n_run++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL rms_cnt: got %0d want 0", a_cnt); end
    a_idle();
  endtask

  task automatic test_long_latency();
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    b_valid = 1'b1; b_src = '0; b_used = 2'b00; b_dst = 5'd4; b_wr = 1'b1; b_ld = 1'b1; b_flush = 1'b0;
    #1;
    n_run++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL ll_issue: got %b want 1", b_ready); end
    tick();
    b_src = {5'd0, 5'd4}; b_used = 2'b01; b_dst = 5'd0; b_wr = 1'b0; b_ld = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_run++; if (b_stall !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL ll_stall%0d: got stall %b ready %b want 1/0", c, b_stall, b_ready); end
      tick();
      n_run++; if (b_cnt !== 8'(c) || b_wd !== (c >= 2)) begin n_fail++; $display("FAIL ll_cnt%0d: got cnt %0d wd %b want %0d/%b", c, b_cnt, b_wd, c, (c >= 2)); end
    end
    #1;
    n_run++; if (b_stall !== 1'b0 || b_ready !== 1'b1 || b_fwd[2:0] !== 3'd4) begin n_fail++; $display("FAIL ll_release: got stall %b ready %b sel %0d want 0/1/4", b_stall, b_ready, b_fwd[2:0]); end
    tick();
    b_valid = 1'b0; b_used = 2'b00;
    repeat (5) tick();
    n_run++; if (b_wd !== 1'b1 || b_cnt !== 8'd0) begin n_fail++; $display("FAIL ll_sticky: got wd %b cnt %0d want 1/0", b_wd, b_cnt); end
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    n_run++; if (b_wd !== 1'b0) begin n_fail++; $display("FAIL ll_wd_clear: got %b want 0", b_wd); end
  endtask

  task automatic test_random();
    a_drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    a_reset = 1'b1;
    tick();
    model_step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      logic       ehz, erdy, estl;
      logic [3:0] esel;
      bit         rst;
      rst     = ($urandom_range(0, 49) == 0);
      a_reset = rst;
      a_drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              2'($urandom), 5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      #1;
      model_eval(a_src, a_used, ehz, esel);
      if (rst) begin
        esel = '0; erdy = 1'b0; estl = 1'b0;
      end else begin
        erdy = a_valid & ~ehz & ~a_flush;
        estl = a_valid & ehz & ~a_flush;
      end
      n_run++; if (a_ready !== erdy || a_stall !== estl || a_hold !== estl) begin n_fail++; $display("FAIL rnd_ctrl c%0d: got ready %b stall %b hold %b want %b/%b/%b", c, a_ready, a_stall, a_hold, erdy, estl, estl); end
      n_run++; if (a_fwd !== esel) begin n_fail++; $display("FAIL rnd_fwd c%0d: got %b want %b", c, a_fwd, esel); end
      tick();
      model_step(rst, erdy, a_dst, a_wr, a_ld, estl);
      n_run++; if (a_cnt !== 8'(m_cnt) || a_wd !== m_wd) begin n_fail++; $display("FAIL rnd_cnt c%0d: got cnt %0d wd %b want %0d/%b", c, a_cnt, a_wd, m_cnt, m_wd); end
    end
    a_reset = 1'b0;
    a_idle();
  endtask

  initial begin
    a_reset = 1'b1;
    a_drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    b_reset = 1'b1; b_valid = 1'b0; b_src = '0; b_used = '0; b_dst = '0;
    b_wr = 1'b0; b_ld = 1'b0; b_flush = 1'b0;
    m_cnt = 0; m_wd = 1'b0;
    tick();
    test_reset();
    test_forward();
    test_load_use();
    test_youngest_r0();
    test_flush();
    test_reset_mid_stall();
    test_long_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
